// File: rtl/exmem_debug_reader.sv
// rtl/exmem_debug_reader.sv - host command decoder and EX/MEM latch stepper/dumper
// A dump snapshots the latch once and then streams the 19-byte frame out of a shift register.
module exmem_debug_reader #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter logic [7:0] CMD_RUN  = 8'h43,
  parameter logic [7:0] CMD_STEP = 8'h53,
  parameter logic [7:0] CMD_DUMP = 8'h44
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [7:0]           i_cmd,
  output logic                 o_cmd_ready,
  output logic                 o_cmd_err,
  output logic                 o_step,
  output logic                 o_halted,
  input  logic [BITS_SIZE-1:0] i_pc4,
  input  logic [BITS_SIZE-1:0] i_instruction,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_register_2,
  input  logic [BITS_REGS-1:0] i_register_rd_dst,
  input  logic                 i_branch,
  input  logic                 i_neq_branch,
  input  logic                 i_mem_write,
  input  logic                 i_mem_read,
  input  logic                 i_zero,
  input  logic                 i_jal,
  input  logic [1:0]           i_datamem_size,
  input  logic [1:0]           i_data_load_size,
  input  logic                 i_mem_to_reg,
  input  logic                 i_register_write,
  input  logic                 i_zero_extend,
  input  logic                 i_lui,
  input  logic                 i_halt,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready
);

  localparam int FW = 4 * BITS_SIZE + 24;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_SNAP, S_DUMP} state_t;

  state_t        state;
  logic [FW-1:0] snap;
  logic [4:0]    idx;
  logic [FW-1:0] frame;

  assign o_cmd_ready = (state == S_IDLE);
  assign o_step      = ((state == S_RUN) && !i_halt) || (state == S_STEP);

  assign frame = {i_pc4, i_instruction, i_alu, i_register_2,
                  i_branch, i_neq_branch, i_mem_write, i_mem_read, i_datamem_size, i_zero, i_jal,
                  i_mem_to_reg, i_register_write, i_data_load_size, i_zero_extend, i_lui, i_halt, 1'b0,
                  3'b000, i_register_rd_dst};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      o_halted   <= 1'b0;
      o_cmd_err  <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      idx        <= 5'd0;
      snap       <= '0;
    end else begin
      o_cmd_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            case (i_cmd)
              CMD_RUN:  if (o_halted) o_cmd_err <= 1'b1; else state <= S_RUN;
              CMD_STEP: if (o_halted) o_cmd_err <= 1'b1; else state <= S_STEP;
              CMD_DUMP: state <= S_SNAP;
              default:  o_cmd_err <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          if (i_halt) begin
            o_halted <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_STEP: begin
          if (i_halt) o_halted <= 1'b1;
          state <= S_IDLE;
        end
        S_SNAP: begin
          // o_step is low here, so the latch holds still while it is captured
          snap       <= frame;
          o_tx_data  <= frame[FW-1 -: 8];
          o_tx_valid <= 1'b1;
          idx        <= 5'd0;
          state      <= S_DUMP;
        end
        S_DUMP: begin
          if (o_tx_valid && i_tx_ready) begin
            if (idx == 5'd18) begin
              o_tx_valid <= 1'b0;
              state      <= S_IDLE;
            end else begin
              idx       <= idx + 5'd1;
              snap      <= {snap[FW-9:0], 8'h00};
              o_tx_data <= snap[FW-9 -: 8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exmem_debug_reader.sv
// tb/tb_exmem_debug_reader.sv - directed self-checking bench for exmem_debug_reader
module tb_exmem_debug_reader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd;
  logic        o_cmd_ready, o_cmd_err, o_step, o_halted;
  logic [31:0] i_pc4, i_instruction, i_alu, i_register_2;
  logic [4:0]  i_register_rd_dst;
  logic        i_branch, i_neq_branch, i_mem_write, i_mem_read, i_zero, i_jal;
  logic [1:0]  i_datamem_size, i_data_load_size;
  logic        i_mem_to_reg, i_register_write, i_zero_extend, i_lui, i_halt;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_frame [0:18];

  exmem_debug_reader dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready), .o_cmd_err(o_cmd_err),
    .o_step(o_step), .o_halted(o_halted),
    .i_pc4(i_pc4), .i_instruction(i_instruction), .i_alu(i_alu), .i_register_2(i_register_2),
    .i_register_rd_dst(i_register_rd_dst),
    .i_branch(i_branch), .i_neq_branch(i_neq_branch), .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
    .i_zero(i_zero), .i_jal(i_jal), .i_datamem_size(i_datamem_size), .i_data_load_size(i_data_load_size),
    .i_mem_to_reg(i_mem_to_reg), .i_register_write(i_register_write), .i_zero_extend(i_zero_extend),
    .i_lui(i_lui), .i_halt(i_halt),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    int steps;
    int k;
    int cyc;
    logic [7:0] prev_data;
    logic       prev_stall;

    exp_frame = '{8'h00, 8'h00, 8'h00, 8'h14, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h00,
                  8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1C, 8'hC0, 8'h03};

    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 8'h00; i_tx_ready = 1'b0;
    i_pc4 = 32'h0; i_instruction = 32'h0; i_alu = 32'h0; i_register_2 = 32'h0;
    i_register_rd_dst = 5'd0; i_branch = 0; i_neq_branch = 0; i_mem_write = 0; i_mem_read = 0;
    i_zero = 0; i_jal = 0; i_datamem_size = 2'b00; i_data_load_size = 2'b00;
    i_mem_to_reg = 0; i_register_write = 0; i_zero_extend = 0; i_lui = 0; i_halt = 0;
    tick(); tick();
    check("rst_step", o_step, 0);
    check("rst_halted", o_halted, 0);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_cmd_err", o_cmd_err, 0);
    check("rst_ready", o_cmd_ready, 1);
    i_reset = 1'b0;
    tick();

    // single step
    send_cmd(8'h53);
    check("step_hi", o_step, 1);
    check("step_busy", o_cmd_ready, 0);
    tick();
    check("step_lo", o_step, 0);
    check("step_ready", o_cmd_ready, 1);

    // run, halt arrives after 7 steps
    send_cmd(8'h43);
    steps = 0;
    for (int i = 0; i < 7; i++) begin
      steps += int'(o_step);
      tick();
    end
    i_halt = 1'b1;
    #1;
    check("run_halt_nostep", o_step, 0);
    tick();
    check("run_step_count", steps, 7);
    check("run_halted", o_halted, 1);
    check("run_idle", o_cmd_ready, 1);

    // commands rejected while halted
    send_cmd(8'h53);
    check("halt_s_err", o_cmd_err, 1);
    check("halt_s_nostep", o_step, 0);
    send_cmd(8'h43);
    check("halt_c_err", o_cmd_err, 1);
    check("halt_c_nostep", o_step, 0);
    tick();
    check("halt_err_clear", o_cmd_err, 0);
    check("halt_still_idle", o_cmd_ready, 1);

    // dump with continuous ready
    i_halt = 1'b0;
    i_pc4 = 32'h00000014; i_instruction = 32'h8C220004; i_alu = 32'h10; i_register_2 = 32'hDEADBEEF;
    i_mem_read = 1'b1; i_datamem_size = 2'b11; i_register_write = 1'b1; i_mem_to_reg = 1'b1;
    i_register_rd_dst = 5'd3;
    i_tx_ready = 1'b1;
    send_cmd(8'h44);
    check("snap_valid_lo", o_tx_valid, 0);
    tick();
    for (int b = 0; b < 19; b++) begin
      check($sformatf("d1_valid_%0d", b), o_tx_valid, 1);
      check($sformatf("d1_byte_%0d", b), o_tx_data, exp_frame[b]);
      tick();
    end
    check("d1_end_valid", o_tx_valid, 0);
    check("d1_end_idle", o_cmd_ready, 1);

    // dump with random backpressure and latch inputs changing mid-frame
    send_cmd(8'h44);
    tick();
    k = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (k < 19 && cyc < 300) begin
      if (o_tx_valid !== 1'b1 || o_tx_data !== exp_frame[k])
        check($sformatf("d2_byte_%0d", k), {o_tx_valid, 23'h0, o_tx_data}, {1'b1, 23'h0, exp_frame[k]});
      if (prev_stall)
        check("d2_stable", o_tx_data, prev_data);
      i_tx_ready = 1'($urandom_range(0, 1));
      i_pc4 = $urandom; i_alu = $urandom; i_register_2 = $urandom; i_instruction = $urandom;
      i_register_rd_dst = 5'($urandom_range(0, 31));
      prev_stall = ~i_tx_ready;
      prev_data  = o_tx_data;
      if (i_tx_ready) k++;
      cyc++;
      tick();
    end
    check("d2_all_bytes", k, 19);
    check("d2_end_valid", o_tx_valid, 0);
    check("d2_end_idle", o_cmd_ready, 1);

    // unknown command
    send_cmd(8'h58);
    check("unk_err", o_cmd_err, 1);
    check("unk_idle", o_cmd_ready, 1);
    tick();
    check("unk_err_clear", o_cmd_err, 0);

    // reset during byte 9 of a dump
    i_pc4 = 32'h00000014; i_instruction = 32'h8C220004; i_alu = 32'h10; i_register_2 = 32'hDEADBEEF;
    i_register_rd_dst = 5'd3;
    i_tx_ready = 1'b1;
    send_cmd(8'h44);
    tick();
    for (int b = 0; b < 9; b++) tick();
    check("rd_byte9_valid", o_tx_valid, 1);
    check("rd_byte9_data", o_tx_data, exp_frame[9]);
    i_reset = 1'b1;
    tick();
    check("rd_valid", o_tx_valid, 0);
    check("rd_data", o_tx_data, 0);
    check("rd_idle", o_cmd_ready, 1);
    check("rd_halted_clr", o_halted, 0);
    i_reset = 1'b0;
    tick();
    check("rd_no_resume", o_tx_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
